// File: rtl/if_stage.sv
// if_stage: instruction fetch stage.
//
// This module owns the program counter. It fetches instructions from
// instruction memory using a req/gnt/rvalid handshake. The fetched
// instruction is held stable until the core asserts advance. The PC then
// steps to pc+4 or to the branch/jump target.
//
// Ports
//   clk, rst_n        core clock; asynchronous active-low reset
//   imem_req/addr     fetch request (high only in FETCH) and its address (= pc)
//   imem_gnt          memory accepted the request this cycle
//   imem_rvalid/rdata response strobe and instruction word
//   instr, op         held instruction and its opcode field instr[6:0]
//   instr_valid       instr is fetched and not yet retired
//   pc, pc_plus4      address of instr and its pc+4 link value
//   advance           core is done with instr; step the PC
//   pcsrc, pc_target  next-PC select (1 = pc_target) and branch/jump target
//   instret           retired-instruction counter (wraps)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FETCH | request driven at pc; waiting for gnt
// ST_WAIT  | request granted; waiting for rvalid
// ST_EXEC  | instr held for the core; waiting for advance
module if_stage #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            advance,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] pc_target,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    // Clears bits [1:0]; there is no compressed ISA, so targets are word aligned.
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] FOUR      = {{(XLEN-3){1'b0}}, 3'b100};

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [31:0]     instret_q, instret_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        instret_d = instret_q;

        case (state_q)
            ST_FETCH: begin
                // Without gnt, any rvalid belongs to an abandoned request.
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // instr is deliberately left as-is; only valid drops.
                if (advance) begin
                    pc_d      = (pcsrc ? pc_target : pc_plus4) & WORD_MASK;
                    valid_d   = 1'b0;
                    instret_d = instret_q + 32'd1;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // Registered request: high in exactly the cycles where state is FETCH.
        req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            req_q     <= 1'b1;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            instret_q <= instret_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + FOUR;
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign instr_valid = valid_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [6:0]  op;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic [31:0] instret;

    if_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .advance     (advance),
        .pcsrc       (pcsrc),
        .pc_target   (pc_target),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_instret = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch from FETCH to EXEC. gnt comes after gnt_dly idle cycles. rvalid comes
    // rv_dly cycles after gnt (0 = same cycle). adv_noise holds advance high
    // throughout, and the DUT must ignore it.
    task automatic do_fetch(input int gnt_dly, input int rv_dly,
                            input logic [31:0] data, input logic adv_noise);
        exp_t e;
        advance = adv_noise;
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < gnt_dly; i++) begin
            imem_gnt = 1'b0;
            imem_rvalid = 1'b0;
            step();
            chk("gnt_wait_req", imem_req, 1);
            chk("gnt_wait_addr", imem_addr, exp_pc);
        end
        imem_gnt = 1'b1;
        imem_rvalid = (rv_dly == 0);
        imem_rdata = (rv_dly == 0) ? data : 32'hBAD0_0BAD;
        sb.push_back('{pc: exp_pc, instr: data});
        step();
        imem_gnt = 1'b0;
        if (rv_dly > 0) begin
            imem_rvalid = 1'b0;
            for (int i = 1; i < rv_dly; i++) begin
                chk("wait_req", imem_req, 0);
                chk("wait_valid", instr_valid, 0);
                step();
            end
            chk("wait_req", imem_req, 0);
            chk("wait_valid", instr_valid, 0);
            chk("wait_addr", imem_addr, exp_pc);
            imem_rvalid = 1'b1;
            imem_rdata = data;
            step();
        end
        imem_rvalid = 1'b0;
        advance = 1'b0;
        chk("valid_rise", instr_valid, 1);
        chk("exec_req", imem_req, 0);
        chk("instret_hold", instret, exp_instret);
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("instr", instr, e.instr);
            chk("pc", pc, e.pc);
            chk("op", {25'd0, op}, {25'd0, e.instr[6:0]});
        end
    endtask

    task automatic do_advance(input logic src, input logic [31:0] tgt);
        chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
        advance = 1'b1;
        pcsrc = src;
        pc_target = tgt;
        exp_pc = (src ? tgt : exp_pc + 32'd4) & 32'hFFFF_FFFC;
        exp_instret = exp_instret + 32'd1;
        step();
        advance = 1'b0;
        pcsrc = 1'b0;
        pc_target = 32'h0;
        chk("adv_valid_clr", instr_valid, 0);
        chk("adv_req", imem_req, 1);
        chk("adv_addr", imem_addr, exp_pc);
        chk("adv_instret", instret, exp_instret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset, checked asynchronously before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", imem_req, 1);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h13);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instret", instret, 0);
        step();
        step();
        rst_n = 1'b1;

        // Zero-wait sequential fetch: 0, 4, 8, C.
        for (int i = 0; i < 4; i++) begin
            do_fetch(0, 0, 32'h0010_0093 + (i << 20), 1'b0);
            do_advance(1'b0, 32'h0);
        end
        chk("instret_4", instret, 32'd4);
        chk("addr_10", imem_addr, 32'h10);

        // Reset asserted while the fetch is in WAIT.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("pre_rst_wait_req", imem_req, 0);
        #2 rst_n = 1'b0;
        #1;
        exp_pc = 32'h0;
        exp_instret = 32'h0;
        chk("mid_rst_req", imem_req, 1);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_instr", instr, 32'h13);
        chk("mid_rst_op", {25'd0, op}, 32'h13);
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_instret", instret, 0);
        step();
        step();
        rst_n = 1'b1;

        // Late/stale response: rvalid without gnt in FETCH must be ignored.
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        imem_rvalid = 1'b0;
        chk("stale_instr", instr, 32'h13);
        chk("stale_valid", instr_valid, 0);
        chk("stale_req", imem_req, 1);
        chk("stale_addr", imem_addr, 32'h0);

        // Wait states: gnt after 2 cycles, rvalid 3 cycles after gnt.
        do_fetch(2, 3, 32'h0050_0093, 1'b0);
        chk("ws_op", {25'd0, op}, 32'h13);
        step();
        chk("exec_hold_valid", instr_valid, 1);
        chk("exec_hold_instr", instr, 32'h0050_0093);
        chk("exec_hold_pc", pc, 32'h0);
        do_advance(1'b0, 32'h0);

        // Reach pc=8, then take a branch to an unaligned target.
        do_fetch(0, 0, 32'h0000_0013, 1'b0);
        do_advance(1'b0, 32'h0);
        do_fetch(0, 0, 32'h0020_8463, 1'b0);
        chk("br_pc8", pc, 32'h8);
        do_advance(1'b1, 32'h0000_0102);
        chk("br_addr", imem_addr, 32'h0000_0100);

        // Jump to the top of the address space, then wrap to 0.
        do_fetch(1, 0, 32'h0000_006F, 1'b0);
        do_advance(1'b1, 32'hFFFF_FFFF);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        do_fetch(1, 2, 32'h0010_0093, 1'b1);
        chk("wrap_pc_hold", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        do_advance(1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
